// File: rtl/async_fifo_pkg.sv
// Shared types and constants for the async FIFO write-side arbiter.
//   WIDTH_DEFAULT : default FIFO data width
//   ERR_CNT_W     : width of the saturating write-error counter
//   state_t       : arbiter FSM state encoding
package async_fifo_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;
    localparam int unsigned ERR_CNT_W     = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/async_fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: selects the first set request at or
// above ptr, wrapping modulo NUM_REQ.
//   req   : request vector
//   ptr   : search start index
//   win_c : one-hot winner (zero when no request)
//   any_c : at least one request is set
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_c,
    output logic               any_c
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // Rotating priority search starting at ptr.
    always_comb begin
        win_c = '0;
        any_c = |req;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                win_c[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// Write-side arbiter sharing one FIFO write port among NUM_REQ requesters.
// Round-robin with packet locking; a grant is released on the owner's last
// beat or after MAX_BURST beats (forced release, flagged by burst_trunc_o).
//   wr_clk_i, rst_i        : write clock, async active-high reset
//   req_valid_i/last_i/data_i, req_ready_o : requester handshakes
//   fifo_full_i, fifo_wr_error_i           : FIFO status
//   fifo_wr_en_o, fifo_wdata_o             : FIFO write port (combinational)
//   grant_o        : one-hot owner, zero when idle
//   burst_trunc_o  : one-cycle pulse after a forced release
//   err_cnt_o      : saturating count of write-error cycles
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEFAULT,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                     wr_clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ-1:0]       req_last_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     fifo_full_i,
    input  logic                     fifo_wr_error_i,
    output logic                     fifo_wr_en_o,
    output logic [WIDTH-1:0]         fifo_wdata_o,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic                     burst_trunc_o,
    output logic [ERR_CNT_W-1:0]     err_cnt_o
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    state_t             state, state_next;
    logic [NUM_REQ-1:0] grant_next;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_next;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_next, cnt_inc;
    logic               trunc_next;

    logic [NUM_REQ-1:0] win_c;
    logic               any_c;
    logic [PTR_W-1:0]   owner_idx;
    logic               owner_valid, owner_last, beat_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req   (req_valid_i),
        .ptr   (rr_ptr),
        .win_c (win_c),
        .any_c (any_c)
    );

    // State register plus arbitration bookkeeping.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= IDLE;
            grant_o       <= '0;
            rr_ptr        <= '0;
            beat_cnt      <= '0;
            burst_trunc_o <= 1'b0;
        end else begin
            state         <= state_next;
            grant_o       <= grant_next;
            rr_ptr        <= rr_ptr_next;
            beat_cnt      <= beat_cnt_next;
            burst_trunc_o <= trunc_next;
        end
    end

    // Next-state: arbitrate in IDLE, count beats and release in GRANT.
    always_comb begin
        state_next    = state;
        grant_next    = grant_o;
        rr_ptr_next   = rr_ptr;
        beat_cnt_next = beat_cnt;
        trunc_next    = 1'b0;
        cnt_inc       = beat_cnt + CNT_W'(1);
        case (state)
            IDLE: begin
                if (any_c) begin
                    grant_next = win_c;
                    state_next = GRANT;
                end
            end
            GRANT: begin
                if (beat_c) begin
                    if (owner_last || (cnt_inc == CNT_W'(MAX_BURST))) begin
                        state_next    = IDLE;
                        grant_next    = '0;
                        beat_cnt_next = '0;
                        rr_ptr_next   = (owner_idx == PTR_W'(NUM_REQ - 1)) ?
                                        '0 : owner_idx + PTR_W'(1);
                        // Last beat wins over the burst limit.
                        trunc_next    = ~owner_last;
                    end else begin
                        beat_cnt_next = cnt_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs: zero-latency mux of the owner onto the FIFO write port.
    always_comb begin
        owner_idx    = '0;
        owner_valid  = 1'b0;
        owner_last   = 1'b0;
        fifo_wdata_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_o[k]) begin
                owner_idx    = PTR_W'(k);
                owner_valid  = req_valid_i[k];
                owner_last   = req_last_i[k];
                fifo_wdata_o = req_data_i[k*WIDTH +: WIDTH];
            end
        end
        beat_c       = owner_valid & ~fifo_full_i;
        req_ready_o  = grant_o & {NUM_REQ{~fifo_full_i}};
        fifo_wr_en_o = beat_c;
    end

    // Saturating write-error counter; cleared only by reset.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_o <= '0;
        end else if (fifo_wr_error_i && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Directed self-checking bench for async_fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4).
module tb_async_fifo_wr_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 4;
    localparam int unsigned MB = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [N*W-1:0] req_data;
    logic           fifo_full, fifo_wr_error, fifo_wr_en, burst_trunc;
    logic [W-1:0]   fifo_wdata;
    logic [15:0]    err_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    logic [W-1:0] wlog[$];

    always #5 clk = ~clk;

    async_fifo_wr_arbiter #(.WIDTH(W), .NUM_REQ(N), .MAX_BURST(MB)) dut (
        .wr_clk_i        (clk),
        .rst_i           (rst),
        .req_valid_i     (req_valid),
        .req_last_i      (req_last),
        .req_data_i      (req_data),
        .req_ready_o     (req_ready),
        .fifo_full_i     (fifo_full),
        .fifo_wr_error_i (fifo_wr_error),
        .fifo_wr_en_o    (fifo_wr_en),
        .fifo_wdata_o    (fifo_wdata),
        .grant_o         (grant),
        .burst_trunc_o   (burst_trunc),
        .err_cnt_o       (err_cnt)
    );

    // Record every beat the FIFO would accept (inputs are stable at negedge).
    always @(negedge clk) if (!rst && fifo_wr_en) wlog.push_back(fifo_wdata);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int k, input logic [W-1:0] d);
        req_data[k*W +: W] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_last = '0; req_data = '1;
        fifo_full = 1'b0; fifo_wr_error = 1'b1;
        tick(); tick();
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
        n_tests++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_tests++; if (fifo_wr_en !== 1'b0 || fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wr: got en=%b data=%h want 0/00", fifo_wr_en, fifo_wdata); end
        n_tests++; if (burst_trunc !== 1'b0 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_misc: got trunc=%b err=%0d want 0/0", burst_trunc, err_cnt); end
        rst = 1'b0; req_valid = '0; req_data = '0; fifo_wr_error = 1'b0;
        tick();
    endtask

    task automatic test_single_packet();
        wlog.delete();
        req_valid = 4'b0100; set_data(2, 8'hA1); #1;
        n_tests++; if (grant !== 4'b0000 || fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL single_pre: got grant=%b data=%h want 0000/00", grant, fifo_wdata); end
        tick();
        n_tests++; if (grant !== 4'b0100 || req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got grant=%b ready=%b want 0100/0100", grant, req_ready); end
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_wdata !== 8'hA1) begin n_fail++; $display("FAIL single_b1: got en=%b data=%h want 1/a1", fifo_wr_en, fifo_wdata); end
        tick(); set_data(2, 8'hA2); #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_wdata !== 8'hA2) begin n_fail++; $display("FAIL single_b2: got en=%b data=%h want 1/a2", fifo_wr_en, fifo_wdata); end
        tick(); set_data(2, 8'hA3); req_last = 4'b0100; #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_wdata !== 8'hA3) begin n_fail++; $display("FAIL single_b3: got en=%b data=%h want 1/a3", fifo_wr_en, fifo_wdata); end
        tick(); req_valid = '0; req_last = '0; #1;
        n_tests++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_release: got grant=%b en=%b want 0000/0", grant, fifo_wr_en); end
        // rr_ptr should now be 3: requester 3 beats requester 0.
        req_valid = 4'b1001; req_last = 4'b1001; set_data(0, 8'h0E); set_data(3, 8'h3E); #1;
        tick();
        n_tests++; if (grant !== 4'b1000 || fifo_wdata !== 8'h3E) begin n_fail++; $display("FAIL single_rrptr: got grant=%b data=%h want 1000/3e", grant, fifo_wdata); end
        req_valid = 4'b1000; #1;
        tick(); req_valid = '0; req_last = '0; #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL single_rr_release: got %b want 0000", grant); end
        n_tests++;
        if (wlog.size() != 4 || wlog[0] !== 8'hA1 || wlog[1] !== 8'hA2 || wlog[2] !== 8'hA3 || wlog[3] !== 8'h3E) begin
            n_fail++; $display("FAIL single_log: got %0d beats want 4 (a1 a2 a3 3e)", wlog.size());
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] eg;
        logic [W-1:0] ed;
        req_valid = '1; req_last = '1;
        for (int k = 0; k < 4; k++) set_data(k, W'(8'h10 + k));
        for (int i = 0; i < 5; i++) begin
            eg = 4'(1 << (i % 4));
            ed = W'(8'h10 + (i % 4));
            tick();
            n_tests++; if (grant !== eg || fifo_wdata !== ed || fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL rr_grant%0d: got grant=%b data=%h en=%b want %b/%h/1", i, grant, fifo_wdata, fifo_wr_en, eg, ed); end
            tick();
            n_tests++; if (grant !== 4'b0000 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rr_bubble%0d: got grant=%b en=%b want 0000/0", i, grant, fifo_wr_en); end
        end
        req_valid = '0; req_last = '0; #1;
    endtask

    task automatic test_back_pressure();
        wlog.delete();
        req_valid = 4'b0001; set_data(0, 8'hC0); #1;
        tick();
        n_tests++; if (grant !== 4'b0001 || fifo_wdata !== 8'hC0 || fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL bp_grant: got grant=%b data=%h en=%b want 0001/c0/1", grant, fifo_wdata, fifo_wr_en); end
        tick(); set_data(0, 8'hC1); #1;
        n_tests++; if (fifo_wdata !== 8'hC1 || fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL bp_b2: got data=%h en=%b want c1/1", fifo_wdata, fifo_wr_en); end
        tick(); set_data(0, 8'hC2); fifo_full = 1'b1; #1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) tick();
            n_tests++; if (req_ready !== 4'b0000 || fifo_wr_en !== 1'b0 || grant !== 4'b0001) begin n_fail++; $display("FAIL bp_full%0d: got ready=%b en=%b grant=%b want 0000/0/0001", c, req_ready, fifo_wr_en, grant); end
        end
        tick(); fifo_full = 1'b0; #1;
        n_tests++; if (fifo_wr_en !== 1'b1 || fifo_wdata !== 8'hC2 || req_ready !== 4'b0001) begin n_fail++; $display("FAIL bp_resume: got en=%b data=%h ready=%b want 1/c2/0001", fifo_wr_en, fifo_wdata, req_ready); end
        tick(); set_data(0, 8'hC3); req_last = 4'b0001; #1;
        tick(); req_valid = '0; req_last = '0; #1;
        // Fourth beat carries last and also hits MAX_BURST: no truncation flag.
        n_tests++; if (grant !== 4'b0000 || burst_trunc !== 1'b0) begin n_fail++; $display("FAIL bp_release: got grant=%b trunc=%b want 0000/0", grant, burst_trunc); end
        n_tests++;
        if (wlog.size() != 4 || wlog[0] !== 8'hC0 || wlog[1] !== 8'hC1 || wlog[2] !== 8'hC2 || wlog[3] !== 8'hC3) begin
            n_fail++; $display("FAIL bp_log: got %0d beats want 4 (c0 c1 c2 c3)", wlog.size());
        end
    endtask

    task automatic test_max_burst();
        req_valid = 4'b1110; req_last = 4'b1100;
        set_data(1, 8'h30); set_data(2, 8'h52); set_data(3, 8'h53); #1;
        tick();
        n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL mb_grant: got %b want 0010", grant); end
        for (int b = 0; b < 4; b++) begin
            n_tests++; if (fifo_wr_en !== 1'b1 || fifo_wdata !== W'(8'h30 + b) || burst_trunc !== 1'b0) begin n_fail++; $display("FAIL mb_beat%0d: got en=%b data=%h trunc=%b want 1/%h/0", b, fifo_wr_en, fifo_wdata, burst_trunc, W'(8'h30 + b)); end
            tick(); set_data(1, W'(8'h31 + b)); #1;
        end
        n_tests++; if (burst_trunc !== 1'b1 || grant !== 4'b0000) begin n_fail++; $display("FAIL mb_trunc: got trunc=%b grant=%b want 1/0000", burst_trunc, grant); end
        tick();
        n_tests++; if (grant !== 4'b0100 || burst_trunc !== 1'b0 || fifo_wdata !== 8'h52) begin n_fail++; $display("FAIL mb_r2: got grant=%b trunc=%b data=%h want 0100/0/52", grant, burst_trunc, fifo_wdata); end
        tick(); req_valid = 4'b1010; #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mb_gap2: got %b want 0000", grant); end
        tick();
        n_tests++; if (grant !== 4'b1000 || fifo_wdata !== 8'h53) begin n_fail++; $display("FAIL mb_r3: got grant=%b data=%h want 1000/53", grant, fifo_wdata); end
        tick(); req_valid = 4'b0010; #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL mb_gap3: got %b want 0000", grant); end
        tick();
        n_tests++; if (grant !== 4'b0010 || fifo_wdata !== 8'h34) begin n_fail++; $display("FAIL mb_regain: got grant=%b data=%h want 0010/34", grant, fifo_wdata); end
        req_last = 4'b0010; #1;
        tick(); req_valid = '0; req_last = '0; #1;
        n_tests++; if (grant !== 4'b0000 || burst_trunc !== 1'b0) begin n_fail++; $display("FAIL mb_end: got grant=%b trunc=%b want 0000/0", grant, burst_trunc); end
    endtask

    task automatic test_error_counter();
        n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL err_start: got %0d want 0", err_cnt); end
        fifo_wr_error = 1'b1;
        repeat (10) tick();
        fifo_wr_error = 1'b0; #1;
        n_tests++; if (err_cnt !== 16'd10) begin n_fail++; $display("FAIL err_count: got %0d want 10", err_cnt); end
        tick();
        n_tests++; if (err_cnt !== 16'd10) begin n_fail++; $display("FAIL err_hold: got %0d want 10", err_cnt); end
    endtask

    task automatic test_reset_mid_packet();
        // rr_ptr is 2 here, so requester 3 wins.
        req_valid = 4'b1000; set_data(3, 8'h77); #1;
        tick();
        n_tests++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rst_pre_grant: got %b want 1000", grant); end
        tick(); #2;
        rst = 1'b1; #1;
        n_tests++; if (grant !== 4'b0000 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_async_grant: got grant=%b ready=%b want 0000/0000", grant, req_ready); end
        n_tests++; if (fifo_wr_en !== 1'b0 || fifo_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_async_wr: got en=%b data=%h want 0/00", fifo_wr_en, fifo_wdata); end
        n_tests++; if (err_cnt !== 16'd0 || burst_trunc !== 1'b0) begin n_fail++; $display("FAIL rst_async_misc: got err=%0d trunc=%b want 0/0", err_cnt, burst_trunc); end
        tick(); rst = 1'b0; req_valid = 4'b1010; set_data(1, 8'h11); #1;
        tick();
        n_tests++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL rst_ptr: got %b want 0010", grant); end
        req_valid = 4'b0010; req_last = 4'b0010; #1;
        tick(); req_valid = '0; req_last = '0; #1;
        n_tests++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL rst_post_release: got %b want 0000", grant); end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_back_pressure();
        test_max_burst();
        test_error_counter();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
